// File: rtl/dt_pkg.sv
// Shared definitions for the two-pass distance-transform engine.
//   DEF_IMG_W / DEF_IMG_H : default image geometry in pixels
//   ADDR_W                : result-memory address width
//   PIX_W                 : pixel / distance width
//   dt_state_e            : engine state encoding
package dt_pkg;

  localparam int DEF_IMG_W = 128;
  localparam int DEF_IMG_H = 128;
  localparam int ADDR_W    = 14;
  localparam int PIX_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_BWD  = 2'd2,
    ST_FIN  = 2'd3
  } dt_state_e;

endpackage

// File: rtl/dt_min_unit.sv
// Combinational minimum of five pixel values, each optionally incremented
// (saturating at the all-ones value) before the compare.
//   din  : five candidate values
//   inc  : per-input "+1" select
//   dmin : smallest candidate after the optional increments
module dt_min_unit
  import dt_pkg::*;
(
  input  logic [4:0][PIX_W-1:0] din,
  input  logic [4:0]            inc,
  output logic [PIX_W-1:0]      dmin
);

  logic [PIX_W-1:0] v;

  always_comb begin
    dmin = '1;
    v    = '0;
    for (int i = 0; i < 5; i++) begin
      if (inc[i] && (din[i] != '1)) v = din[i] + PIX_W'(1);
      else                          v = din[i];
      if (v < dmin) dmin = v;
    end
  end

endmodule

// File: rtl/dt_pass_engine.sv
// Two-pass (forward raster, then reverse raster) chessboard distance
// transform performed in place on an external result memory.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   start    : one-cycle request to run both passes (accepted in IDLE/FIN)
//   done     : high from pass completion until the next accepted start
//   res_rd   : memory read strobe, data returns on res_di one cycle later
//   res_wr   : memory write strobe
//   res_addr : memory address, row*IMG_W+col
//   res_do   : memory write data
//   res_di   : memory read data
//
// state | meaning
// IDLE  | after reset, waiting for start, no memory traffic
// FWD   | forward pass over interior pixels, ascending raster order
// BWD   | backward pass over interior pixels, descending raster order
// FIN   | both passes complete, done high, waiting for start
//
// Each pixel takes 7 slots: s0..s4 issue reads (C first, then four
// neighbours), s5 receives the last neighbour and registers the result,
// s6 writes the pixel back when it is an object pixel.
module dt_pass_engine
  import dt_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              res_rd,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [PIX_W-1:0]  res_do,
  input  logic [PIX_W-1:0]  res_di
);

  localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] COL_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - 2);
  localparam logic [2:0]        SLOT_RD_LAST = 3'd4;
  localparam logic [2:0]        SLOT_CAP     = 3'd5;
  localparam logic [2:0]        SLOT_WR      = 3'd6;

  dt_state_e                state, state_nx;
  logic [2:0]               slot, slot_nx;
  logic [ADDR_W-1:0]        row, row_nx, col, col_nx;
  logic [ADDR_W-1:0]        base_nx, addr_nx;
  logic                     busy, busy_nx, fwd_nx;
  logic                     rd_nx, wr_nx, done_nx;
  logic [3:0][PIX_W-1:0]    nb;
  logic [4:0][PIX_W-1:0]    min_din;
  logic [PIX_W-1:0]         min_out;

  // Input 0 is the centre pixel in the backward pass; in the forward pass
  // it is parked at the maximum so only the four +1 neighbours compete.
  always_comb begin
    min_din[0] = (state == ST_FWD) ? '1 : nb[0];
    min_din[1] = nb[1];
    min_din[2] = nb[2];
    min_din[3] = nb[3];
    min_din[4] = res_di;
  end

  dt_min_unit u_min (
    .din  (min_din),
    .inc  (5'b11110),
    .dmin (min_out)
  );

  assign busy = (state == ST_FWD) || (state == ST_BWD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    row_nx   = row;
    col_nx   = col;
    case (state)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          state_nx = ST_FWD;
          slot_nx  = '0;
          row_nx   = ROW_FIRST;
          col_nx   = COL_FIRST;
        end
      end
      ST_FWD: begin
        if (slot == SLOT_WR) begin
          slot_nx = '0;
          if (col == COL_LAST) begin
            // Backward pass starts at the same last pixel, so row stays.
            if (row == ROW_LAST) begin
              state_nx = ST_BWD;
            end else begin
              col_nx = COL_FIRST;
              row_nx = row + ADDR_W'(1);
            end
          end else begin
            col_nx = col + ADDR_W'(1);
          end
        end else begin
          slot_nx = slot + 3'd1;
        end
      end
      ST_BWD: begin
        if (slot == SLOT_WR) begin
          slot_nx = '0;
          if (col == COL_FIRST) begin
            if (row == ROW_FIRST) begin
              state_nx = ST_FIN;
            end else begin
              col_nx = COL_LAST;
              row_nx = row - ADDR_W'(1);
            end
          end else begin
            col_nx = col - ADDR_W'(1);
          end
        end else begin
          slot_nx = slot + 3'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle slot.
    busy_nx = (state_nx == ST_FWD) || (state_nx == ST_BWD);
    fwd_nx  = (state_nx == ST_FWD);
    done_nx = (state_nx == ST_FIN);
    rd_nx   = busy_nx && (slot_nx <= SLOT_RD_LAST);
    wr_nx   = busy_nx && (slot_nx == SLOT_WR) && (nb[0] != '0);
    base_nx = row_nx * W_A + col_nx;
    addr_nx = '0;
    if (busy_nx) begin
      case (slot_nx)
        3'd1:    addr_nx = fwd_nx ? base_nx - W_A - ADDR_W'(1) : base_nx + ADDR_W'(1);
        3'd2:    addr_nx = fwd_nx ? base_nx - W_A              : base_nx + W_A - ADDR_W'(1);
        3'd3:    addr_nx = fwd_nx ? base_nx - W_A + ADDR_W'(1) : base_nx + W_A;
        3'd4:    addr_nx = fwd_nx ? base_nx - ADDR_W'(1)       : base_nx + W_A + ADDR_W'(1);
        default: addr_nx = base_nx;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot     <= '0;
      row      <= '0;
      col      <= '0;
      nb       <= '0;
      done     <= 1'b0;
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
    end else begin
      slot     <= slot_nx;
      row      <= row_nx;
      col      <= col_nx;
      done     <= done_nx;
      res_rd   <= rd_nx;
      res_wr   <= wr_nx;
      res_addr <= addr_nx;
      if (busy) begin
        case (slot)
          3'd1:     nb[0]  <= res_di;
          3'd2:     nb[1]  <= res_di;
          3'd3:     nb[2]  <= res_di;
          3'd4:     nb[3]  <= res_di;
          SLOT_CAP: res_do <= min_out;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dt_pass_engine.sv
module tb_dt_pass_engine;
  import dt_pkg::*;

  localparam int TW    = 128;
  localparam int TH    = 16;
  localparam int NPIX  = TW * TH;
  localparam int BUSY  = 2 * (TH - 2) * (TW - 2) * 7;
  localparam int LIMIT = BUSY + 200;
  localparam int MID_K = 500;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              done, res_rd, res_wr;
  logic [ADDR_W-1:0] res_addr;
  logic [PIX_W-1:0]  res_do;
  logic [PIX_W-1:0]  res_di = '0;

  always #5 clk = ~clk;

  dt_pass_engine #(.IMG_W(TW), .IMG_H(TH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .res_rd   (res_rd),
    .res_wr   (res_wr),
    .res_addr (res_addr),
    .res_do   (res_do),
    .res_di   (res_di)
  );

  logic [7:0] mem [NPIX];
  logic [7:0] img [NPIX];
  logic       load = 1'b0;
  int wr_cnt, wr645_cnt, wr645_bad, wr129_cnt, border_wr, overlap_cnt, acc_cnt;
  logic [7:0] first129 = '0;

  // Memory model: registered read, write at end of strobe cycle.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NPIX; i++) mem[i] <= img[i];
      wr_cnt <= 0; wr645_cnt <= 0; wr645_bad <= 0; wr129_cnt <= 0;
      border_wr <= 0; overlap_cnt <= 0; acc_cnt <= 0;
    end else begin
      if (res_rd && int'(res_addr) < NPIX) res_di <= mem[res_addr];
      if (res_rd || res_wr) acc_cnt <= acc_cnt + 1;
      if (res_rd && res_wr) overlap_cnt <= overlap_cnt + 1;
      if (res_wr && int'(res_addr) < NPIX) begin
        mem[res_addr] <= res_do;
        wr_cnt <= wr_cnt + 1;
        if (int'(res_addr) == 645) begin
          wr645_cnt <= wr645_cnt + 1;
          if (res_do != 8'd1) wr645_bad <= wr645_bad + 1;
        end
        if (int'(res_addr) == 129) begin
          if (wr129_cnt == 0) first129 <= res_do;
          wr129_cnt <= wr129_cnt + 1;
        end
        if (int'(res_addr) < TW || int'(res_addr) >= (TH - 1) * TW ||
            int'(res_addr) % TW == 0 || int'(res_addr) % TW == TW - 1)
          border_wr <= border_wr + 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_img();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic run_pass(input bit mid, input bit from_fin);
    int k;
    bit seen;
    @(negedge clk);
    if (from_fin) check("done_before_start", int'(done), 1);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("done_after_start", int'(done), 0);
    check("first_rd", int'(res_rd), 1);
    check("first_addr", int'(res_addr), TW + 1);
    k = 0; seen = 1'b0;
    while (!seen && k < LIMIT) begin
      @(posedge clk); #1; k++;
      start = (mid && k == MID_K);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_latency", seen ? k : -1, BUSY);
  endtask

  task automatic build_obj_img();
    for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
    img[5 * TW + 5] = 8'd1;
    for (int r = 10; r <= 14; r++)
      for (int c = 10; c <= 14; c++) img[r * TW + c] = 8'd1;
    // (1,1) sees only border neighbours at 255 in the forward pass.
    img[0] = 8'd255; img[1] = 8'd255; img[2] = 8'd255; img[TW] = 8'd255;
    img[TW + 1] = 8'd5;
  endtask

  typedef struct {
    int row;
    int col;
    int exp;
  } mem_vec_t;

  mem_vec_t vecs [16];

  task automatic check_table(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_mem_r%0d_c%0d", tag, vecs[i].row, vecs[i].col),
            int'(mem[vecs[i].row * TW + vecs[i].col]), vecs[i].exp);
  endtask

  initial begin
    int nz;
    int snap;
    vecs[0]  = '{12, 12, 3};  vecs[1]  = '{11, 11, 2};
    vecs[2]  = '{13, 13, 2};  vecs[3]  = '{11, 13, 2};
    vecs[4]  = '{12, 11, 2};  vecs[5]  = '{10, 10, 1};
    vecs[6]  = '{14, 12, 1};  vecs[7]  = '{12, 10, 1};
    vecs[8]  = '{10, 14, 1};  vecs[9]  = '{9, 12, 0};
    vecs[10] = '{12, 15, 0};  vecs[11] = '{15, 12, 0};
    vecs[12] = '{5, 5, 1};    vecs[13] = '{1, 1, 1};
    vecs[14] = '{0, 1, 255};  vecs[15] = '{1, 2, 0};

    repeat (3) @(negedge clk);
    check("rst_done", int'(done), 0);
    check("rst_rd", int'(res_rd), 0);
    check("rst_wr", int'(res_wr), 0);
    check("rst_addr", int'(res_addr), 0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_no_access", acc_cnt, 0);

    // All-zero image with a stray start mid forward pass.
    for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
    load_img();
    run_pass(1'b1, 1'b0);
    check("zero_wr_cnt", wr_cnt, 0);
    nz = 0;
    for (int i = 0; i < NPIX; i++) if (mem[i] !== 8'd0) nz++;
    check("zero_mem_changed", nz, 0);

    // Object image, started from FIN.
    build_obj_img();
    load_img();
    run_pass(1'b0, 1'b1);
    check_table("obj");
    check("wr645_cnt", wr645_cnt, 2);
    check("wr645_bad", wr645_bad, 0);
    check("sat_first_wr", int'(first129), 255);
    check("wr129_cnt", wr129_cnt, 2);
    check("obj_wr_cnt", wr_cnt, 54);
    check("border_wr", border_wr, 0);
    check("rd_wr_overlap", overlap_cnt, 0);

    // Reset 1000 cycles into the forward pass, then rerun.
    load_img();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (1000) @(posedge clk);
    #1; reset = 1'b0;
    #1;
    check("abort_rd", int'(res_rd), 0);
    check("abort_wr", int'(res_wr), 0);
    check("abort_addr", int'(res_addr), 0);
    check("abort_do", int'(res_do), 0);
    check("abort_done", int'(done), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    snap = acc_cnt;
    repeat (50) @(posedge clk);
    #1;
    check("post_rst_no_access", acc_cnt - snap, 0);
    check("post_rst_done", int'(done), 0);
    load_img();
    run_pass(1'b0, 1'b0);
    check_table("rerun");
    check("rerun_wr_cnt", wr_cnt, 54);
    check("rerun_overlap", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dt_pass_engine.md
DT_PASS_ENGINE -- requirements
Module: dt_pass_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  IMG_W, 128, image width in pixels.
  IMG_H, 128, image height in pixels.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on the rising edge.
  reset  in  1  asynchronous, active-low reset.
  start  in  1  one-cycle pulse; starts the two-pass distance transform over the 0/1 image already in res memory.
  done  out  1  high from pass completion until the next accepted start.
  res_rd  out  1  res memory read strobe.
  res_wr  out  1  res memory write strobe.
  res_addr  out  14  res memory address, row*IMG_W+col.
  res_do  out  8  res memory write data.
  res_di  in  8  res memory read data.
REQ-003 The block SHALL use one clock (clk) and SHALL use an asynchronous, active-low reset (reset).

Function
REQ-004 All outputs SHALL be registered.
REQ-005 Read timing: res_rd=1 with res_addr=A in cycle t SHALL yield mem[A] on res_di in cycle t+1, which the block SHALL capture at the end of t+1.
REQ-006 Write timing: res_wr=1 in cycle t SHALL write res_do to res_addr at the end of t.
REQ-007 States: IDLE, FWD, BWD, FIN.
  - IDLE->FWD on start.
  - FWD->BWD after the last forward pixel.
  - BWD->FIN after the last backward pixel.
  - FIN->FWD on start.
REQ-008 start SHALL be ignored in FWD and BWD.
REQ-009 Forward scan SHALL visit rows 1..IMG_H-2 and cols 1..IMG_W-2 in ascending raster order.
REQ-010 Backward scan SHALL visit the same pixels in exactly reversed order.
REQ-011 Border row/col pixels SHALL never be read or written.
REQ-012 Each pixel SHALL take exactly 7 cycles, slots s0..s6:
  - s0..s4: read one address per cycle.
    - Forward order: C, NW, N, NE, W.
    - Backward order: C, E, SW, S, SE.
  - s5: capture the last datum.
  - s6: write C or idle.
REQ-013 In s6, if C==0, res_wr SHALL stay 0 and the pixel SHALL be left unchanged.
REQ-014 In s6, if C!=0, forward SHALL write min(NW,N,NE,W)+1.
REQ-015 In s6, if C!=0, backward SHALL write min(C, E+1, SW+1, S+1, SE+1).
REQ-016 All +1 operations SHALL saturate at 255.
REQ-017 Ties in any min SHALL have no observable effect.
REQ-018 The backward pass SHALL read the values written by the forward pass.
REQ-019 The forward pass SHALL read its own earlier writes (in-place).
REQ-020 res_rd and res_wr SHALL never be high in the same cycle.
REQ-021 res_rd SHALL be 0 in s5 and s6.
REQ-022 Total busy time SHALL be 2*(IMG_H-2)*(IMG_W-2)*7 cycles, i.e. 222264 cycles at default parameters.
REQ-023 done SHALL rise in the first FIN cycle.
REQ-024 done SHALL fall in the cycle after a start accepted in FIN.

Reset
REQ-025 On reset low, state SHALL become IDLE immediately (asynchronously).
REQ-026 On reset low, done, res_rd, res_wr, res_addr and res_do SHALL all become 0 immediately.
REQ-027 On reset low, row/col/slot counters and neighbour registers SHALL clear.
REQ-028 Reset mid-pass SHALL abort with no further writes; memory contents are then undefined, and a fresh start SHALL be required.
REQ-029 After reset release, no memory access SHALL occur before start.

Structure
REQ-030 Package dt_pkg SHALL hold IMG_W and IMG_H defaults, ADDR_W=14, PIX_W=8, and the state encoding.
REQ-031 Sub-module dt_min_unit SHALL be a combinational min of five 8-bit inputs with a per-input saturating +1 select.
REQ-032 dt_pass_engine SHALL instantiate dt_min_unit once, shared by both passes.

Verification
REQ-033 All-zero image, start -> no res_wr ever; done rises exactly 222264 cycles after start; memory unchanged.
REQ-034 Single object pixel at (5,5), value 1 -> final mem[645]=1; exactly two writes, both to address 645 with value 1.
REQ-035 Filled 5x5 object square, rows 10..14, cols 10..14 -> centre (12,12) final value 3; ring values 1 and 2; all background stays 0.
REQ-036 Start pulse asserted mid-FWD -> ignored; done timing identical to REQ-033.
REQ-037 Reset low at cycle 1000 of FWD -> all outputs 0 in the same cycle; no res_rd/res_wr until a new start; rerun yields the correct result.
REQ-038 Forward-pass neighbour value 255 (saturation) -> written value 255, not 0.
